evm_ballot_unit: RTL and testbench

//  Voter-side ballot unit: the transmitting end of the vote-strobe interface into the EVM control/tally unit.

---
 rtl/evm_pkg.sv | 31 +++
 rtl/evm_debounce.sv | 67 ++++++
 rtl/evm_ballot_unit.sv | 98 +++++++++
 tb/tb_evm_ballot_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/evm_pkg.sv
// Shared types and constants for the EVM ballot unit.
package evm_pkg;

    // Candidate identifiers carried on vote_cand.
    localparam logic [1:0] CAND_A = 2'd0;
    localparam logic [1:0] CAND_B = 2'd1;
    localparam logic [1:0] CAND_C = 2'd2;

    // Stable synchronised samples needed before a button level is accepted.
    localparam int DEBOUNCE_CYCLES_DEFAULT = 65535;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        SEND    = 2'd2,
        RELEASE = 2'd3
    } ballot_state_e;

    // Number of press pulses present in one cycle (0..3).
    function automatic logic [1:0] press_count(input logic [2:0] press);
        return 2'(press[0]) + 2'(press[1]) + 2'(press[2]);
    endfunction

    // Candidate id of a one-hot press vector (bit 0 = A, bit 1 = B, bit 2 = C).
    function automatic logic [1:0] press_to_cand(input logic [2:0] press);
        if (press[0]) return CAND_A;
        if (press[1]) return CAND_B;
        return CAND_C;
    endfunction

endpackage

// File: rtl/evm_debounce.sv
// One button channel: 2-flop synchroniser, stability counter, debounced level
// and a registered one-cycle press pulse on each debounced 0->1 transition.
module evm_debounce #(
    parameter int CNT_W           = 16,
    parameter int DEBOUNCE_CYCLES = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    // The sample that completes a run of DEBOUNCE_CYCLES mismatches flips the level.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             prev_q,  prev_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // Next-state: synchronise, count consecutive disagreeing samples, detect rise.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path leaves it
        // unassigned; an unassigned path would infer a latch.
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        prev_d  = level_q;
        press_d = level_q & ~prev_q;
        if (sync2_q != level_q) begin
            if (cnt_q == LAST_CNT) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // the pre-edge value of its inputs regardless of statement order.
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            prev_q  <= prev_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/evm_ballot_unit.sv
// Voter-side ballot unit: debounces three candidate buttons, accepts one vote
// per issued ballot and offers it once over a valid/ready handshake.
module evm_ballot_unit
    import evm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ballot_issue,
    input  logic       btn_a,
    input  logic       btn_b,
    input  logic       btn_c,
    output logic       vote_valid,
    output logic [1:0] vote_cand,
    input  logic       vote_ready,
    output logic       ready_led,
    output logic       busy_led,
    output logic       multi_press
);

    logic [2:0]    btn_raw;
    logic [2:0]    level;
    logic [2:0]    press;
    logic [1:0]    n_press;

    ballot_state_e state_q, state_d;
    logic [1:0]    cand_q,  cand_d;
    logic          multi_q, multi_d;

    assign btn_raw = {btn_c, btn_b, btn_a};
    assign n_press = press_count(press);

    for (genvar i = 0; i < 3; i++) begin : g_btn
        evm_debounce #(
            .CNT_W           (CNT_W),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .rst     (rst),
            .btn_raw (btn_raw[i]),
            .level   (level[i]),
            .press   (press[i])
        );
    end

    // Ballot FSM: arm on issue, capture exactly one press, hold the offer until
    // accepted, then wait for every button to be released.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        multi_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ballot_issue) state_d = ARMED;
            end
            ARMED: begin
                if (n_press == 2'd1) begin
                    cand_d  = press_to_cand(press);
                    state_d = SEND;
                end else if (n_press >= 2'd2) begin
                    multi_d = 1'b1;
                end
            end
            SEND: begin
                if (vote_ready) state_d = RELEASE;
            end
            RELEASE: begin
                if (level == 3'b000) begin
                    state_d = IDLE;
                    cand_d  = CAND_A;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, captured candidate and multi-press pulse registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cand_q  <= CAND_A;
            multi_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            multi_q <= multi_d;
        end
    end

    assign vote_valid  = (state_q == SEND);
    assign vote_cand   = cand_q;
    assign ready_led   = (state_q == ARMED);
    assign busy_led    = (state_q == SEND) || (state_q == RELEASE);
    assign multi_press = multi_q;

endmodule

// File: tb/tb_evm_ballot_unit.sv
// Self-checking bench for evm_ballot_unit with a short debounce window.
module tb_evm_ballot_unit;

    localparam int DEB = 4;
    localparam int CW  = 3;
    localparam int HL  = DEB + 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       ballot_issue;
    logic       btn_a, btn_b, btn_c;
    logic       vote_valid;
    logic [1:0] vote_cand;
    logic       vote_ready;
    logic       ready_led;
    logic       busy_led;
    logic       multi_press;

    evm_ballot_unit #(
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ballot_issue (ballot_issue),
        .btn_a        (btn_a),
        .btn_b        (btn_b),
        .btn_c        (btn_c),
        .vote_valid   (vote_valid),
        .vote_cand    (vote_cand),
        .vote_ready   (vote_ready),
        .ready_led    (ready_led),
        .busy_led     (busy_led),
        .multi_press  (multi_press)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         xfer_cnt = 0;
    int         mp_cnt = 0;
    logic [1:0] last_cand = 2'd0;

    // Reference model: raw sample history per button; a level is accepted when the
    // last DEB synchronised samples (raw delayed two cycles) all disagree with it.
    bit [HL-1:0] m_hist [3];
    bit [2:0]    m_lvl, m_prev, m_press;
    bit          m_armed, m_offer, m_release, m_multi;
    bit [1:0]    m_cand;

    function automatic int popc(input bit [2:0] v);
        return int'(v[0]) + int'(v[1]) + int'(v[2]);
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit [2:0]     raw;
        bit [2:0]     nl;
        bit [DEB-1:0] w;
        int           n;
        raw = {btn_c, btn_b, btn_a};
        if (!rst) begin
            for (int i = 0; i < 3; i++) m_hist[i] = '0;
            m_lvl = '0; m_prev = '0; m_press = '0;
            m_armed = 0; m_offer = 0; m_release = 0; m_multi = 0; m_cand = 2'd0;
        end else begin
            n  = popc(m_press);
            nl = m_lvl;
            for (int i = 0; i < 3; i++) begin
                m_hist[i] = {m_hist[i][HL-2:0], raw[i]};
                w = m_hist[i][DEB+1:2];
                if (m_lvl[i] ? (w == '0) : (&w)) nl[i] = ~m_lvl[i];
            end
            m_multi = m_armed && (n >= 2);
            if (m_offer) begin
                if (vote_ready) begin m_offer = 0; m_release = 1; end
            end else if (m_release) begin
                if (m_lvl == 3'b000) begin m_release = 0; m_cand = 2'd0; end
            end else if (m_armed) begin
                if (n == 1) begin
                    m_armed = 0;
                    m_offer = 1;
                    m_cand  = m_press[0] ? 2'd0 : (m_press[1] ? 2'd1 : 2'd2);
                end
            end else if (ballot_issue) begin
                m_armed = 1;
            end
            m_press = m_lvl & ~m_prev;
            m_prev  = m_lvl;
            m_lvl   = nl;
        end
    endtask

    // One clock: log a completing handshake, advance the model, compare outputs.
    task automatic tick();
        if (rst && vote_valid && vote_ready) begin
            xfer_cnt++;
            last_cand = vote_cand;
        end
        @(posedge clk);
        model_step();
        #1;
        if (multi_press) mp_cnt++;
        check("vote_valid",  8'(vote_valid),  8'(m_offer));
        check("vote_cand",   8'(vote_cand),   8'(m_cand));
        check("ready_led",   8'(ready_led),   8'(m_armed));
        check("busy_led",    8'(busy_led),    8'(m_offer | m_release));
        check("multi_press", 8'(multi_press), 8'(m_multi));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic issue_ballot();
        ballot_issue = 1'b1;
        tick();
        ballot_issue = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int max);
        int k;
        k = 0;
        while (!vote_valid && k < max) begin
            tick();
            k++;
        end
        check(tag, 8'(vote_valid), 8'd1);
    endtask

    int x0;
    int mp0;

    initial begin
        rst = 1'b0; ballot_issue = 1'b0; vote_ready = 1'b0;
        btn_a = 1'b0; btn_b = 1'b0; btn_c = 1'b0;
        ticks(3);
        check("rst_valid", 8'(vote_valid), 8'd0);
        check("rst_cand",  8'(vote_cand),  8'd0);
        check("rst_ready", 8'(ready_led),  8'd0);
        check("rst_busy",  8'(busy_led),   8'd0);
        rst = 1'b1;
        ticks(2);

        // 1: single press of B with the tally unit always ready.
        x0 = xfer_cnt;
        vote_ready = 1'b1;
        issue_ballot();
        check("t1_ready_on", 8'(ready_led), 8'd1);
        btn_b = 1'b1;
        ticks(10 + int'($urandom_range(0, 4)));
        check("t1_xfer",      8'(xfer_cnt - x0), 8'd1);
        check("t1_cand",      8'(last_cand),     8'd1);
        check("t1_ready_off", 8'(ready_led),     8'd0);
        check("t1_busy_held", 8'(busy_led),      8'd1);
        btn_b = 1'b0;
        ticks(10);
        check("t1_busy_clr",  8'(busy_led),      8'd0);

        // 2: bouncing A shorter than the window, then a clean hold.
        x0 = xfer_cnt;
        issue_ballot();
        for (int i = 0; i < 6; i++) begin
            btn_a = ~btn_a;
            ticks(2);
        end
        check("t2_no_early", 8'(xfer_cnt - x0), 8'd0);
        check("t2_armed",    8'(ready_led),     8'd1);
        btn_a = 1'b1;
        wait_valid("t2_wait", 20);
        check("t2_cand", 8'(vote_cand), 8'd0);
        tick();
        check("t2_xfer", 8'(xfer_cnt - x0), 8'd1);
        btn_a = 1'b0;
        ticks(12);

        // 3: A and C together -> multi_press, then C alone.
        x0 = xfer_cnt; mp0 = mp_cnt;
        issue_ballot();
        btn_a = 1'b1; btn_c = 1'b1;
        ticks(10);
        check("t3_multi",    8'(mp_cnt - mp0),  8'd1);
        check("t3_no_valid", 8'(vote_valid),    8'd0);
        check("t3_armed",    8'(ready_led),     8'd1);
        btn_a = 1'b0; btn_c = 1'b0;
        ticks(10);
        btn_c = 1'b1;
        wait_valid("t3_wait", 20);
        check("t3_cand", 8'(vote_cand), 8'd2);
        tick();
        check("t3_xfer", 8'(xfer_cnt - x0), 8'd1);
        btn_c = 1'b0;
        ticks(12);

        // 4: back-pressure holds the offer; other presses are dropped.
        x0 = xfer_cnt;
        vote_ready = 1'b0;
        issue_ballot();
        btn_b = 1'b1;
        wait_valid("t4_wait", 20);
        for (int i = 0; i < 20; i++) begin
            if (i == 3) btn_a = 1'b1;
            if (i == 9) btn_c = 1'b1;
            tick();
            check("t4_hold_valid", 8'(vote_valid), 8'd1);
            check("t4_hold_cand",  8'(vote_cand),  8'd1);
        end
        check("t4_no_xfer", 8'(xfer_cnt - x0), 8'd0);
        vote_ready = 1'b1;
        tick();
        check("t4_xfer",      8'(xfer_cnt - x0), 8'd1);
        check("t4_cand",      8'(last_cand),     8'd1);
        check("t4_valid_off", 8'(vote_valid),    8'd0);
        btn_a = 1'b0; btn_b = 1'b0; btn_c = 1'b0;
        ticks(14);

        // 5: C held across ballot_issue produces nothing until re-pressed.
        x0 = xfer_cnt;
        btn_c = 1'b1;
        ticks(10);
        issue_ballot();
        ticks(15);
        check("t5_no_xfer", 8'(xfer_cnt - x0), 8'd0);
        check("t5_armed",   8'(ready_led),     8'd1);
        btn_c = 1'b0;
        ticks(8);
        btn_c = 1'b1;
        wait_valid("t5_wait", 20);
        check("t5_cand", 8'(vote_cand), 8'd2);
        tick();
        check("t5_xfer", 8'(xfer_cnt - x0), 8'd1);
        btn_c = 1'b0;
        ticks(12);

        // 6: reset during SEND abandons the vote; presses without a ballot do nothing.
        x0 = xfer_cnt;
        vote_ready = 1'b0;
        issue_ballot();
        btn_a = 1'b1;
        wait_valid("t6_wait", 20);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("t6_valid_off", 8'(vote_valid), 8'd0);
        check("t6_idle_rdy",  8'(ready_led),  8'd0);
        check("t6_idle_busy", 8'(busy_led),   8'd0);
        ticks(10);
        btn_a = 1'b0;
        ticks(8);
        btn_a = 1'b1;
        ticks(10);
        vote_ready = 1'b1;
        ticks(3);
        check("t6_no_xfer",  8'(xfer_cnt - x0), 8'd0);
        check("t6_no_valid", 8'(vote_valid),    8'd0);
        btn_a = 1'b0;
        ticks(8);

        // Random soak against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) btn_a = ~btn_a;
            if ($urandom_range(0, 7) == 0) btn_b = ~btn_b;
            if ($urandom_range(0, 7) == 0) btn_c = ~btn_c;
            ballot_issue = ($urandom_range(0, 19) == 0);
            vote_ready   = 1'($urandom_range(0, 1));
            rst          = ($urandom_range(0, 499) != 0);
            tick();
        end
        rst = 1'b1; ballot_issue = 1'b0;
        ticks(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
